// File: rtl/osc_ctrl_pkg.sv
// Shared types and constants for the programmable divided-clock generator.
package osc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        LO    = 2'd2,
        HI    = 2'd3
    } osc_state_e;

    localparam int OSC_MIN_PERIOD = 2;

endpackage

// File: rtl/osc_downcnt.sv
// Loadable down-counter; holds at zero rather than wrapping.
// Load takes priority; zero reflects the registered count.
module osc_downcnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/osc_ctrl.sv
// Divided-clock generator: programmable period and start phase, glitch-free start/stop.
// Outputs registered; configuration only accepted while idle (cfg_ready low otherwise).
module osc_ctrl
    import osc_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int RST_PERIOD = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_phase,
    output logic             cfg_err,
    output logic             div_clk,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             running
);

    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MIN_PER = CNT_W'(OSC_MIN_PERIOD);

    osc_state_e       state_q, state_d;
    logic [CNT_W-1:0] per_q, ph_q;
    logic [CNT_W-1:0] hi_len, lo_len;
    logic             div_clk_q, rise_stb_q, fall_stb_q, cfg_err_q;
    logic             cnt_load, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             cfg_fire;

    assign hi_len   = per_q >> 1;
    assign lo_len   = per_q - hi_len;
    assign cfg_fire = cfg_valid && (state_q == IDLE);

    // A pending configuration in IDLE takes precedence over starting.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        unique case (state_q)
            IDLE: begin
                if (!cfg_valid && enable) begin
                    cnt_load = 1'b1;
                    if (ph_q != '0) begin
                        state_d = PHASE;
                        cnt_val = ph_q - ONE;
                    end else begin
                        state_d = LO;
                        cnt_val = lo_len - ONE;
                    end
                end
            end
            PHASE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    state_d  = LO;
                    cnt_load = 1'b1;
                    cnt_val  = lo_len - ONE;
                end
            end
            LO: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    state_d  = HI;
                    cnt_load = 1'b1;
                    cnt_val  = hi_len - ONE;
                end
            end
            HI: begin
                if (cnt_zero) begin
                    if (enable) begin
                        state_d  = LO;
                        cnt_load = 1'b1;
                        cnt_val  = lo_len - ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    osc_downcnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            per_q      <= CNT_W'(RST_PERIOD);
            ph_q       <= '0;
            div_clk_q  <= 1'b0;
            rise_stb_q <= 1'b0;
            fall_stb_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_clk_q  <= (state_d == HI);
            rise_stb_q <= (state_q != HI) && (state_d == HI);
            fall_stb_q <= (state_q == HI) && (state_d != HI);
            cfg_err_q  <= cfg_fire && (cfg_period < MIN_PER);
            if (cfg_fire && (cfg_period >= MIN_PER)) begin
                per_q <= cfg_period;
                ph_q  <= cfg_phase;
            end
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign running   = (state_q != IDLE);
    assign div_clk   = div_clk_q;
    assign rise_stb  = rise_stb_q;
    assign fall_stb  = fall_stb_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_osc_ctrl.sv
// Scoreboard bench for osc_ctrl: a time-based reference model predicts every cycle's outputs.
module tb_osc_ctrl;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic div;
        logic rise;
        logic fall;
        logic run;
        logic rdy;
        logic err;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [CNT_W-1:0] cfg_phase = '0;
    logic             cfg_ready, cfg_err, div_clk, rise_stb, fall_stb, running;

    always #5 clk = ~clk;

    osc_ctrl #(.CNT_W(CNT_W), .RST_PERIOD(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_phase  (cfg_phase),
        .cfg_err    (cfg_err),
        .div_clk    (div_clk),
        .rise_stb   (rise_stb),
        .fall_stb   (fall_stb),
        .running    (running)
    );

    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];

    // Reference model: the waveform is a pure function of cycles since start.
    int m_per = 2;
    int m_ph  = 0;
    int m_t   = 0;
    bit m_act = 1'b0;
    bit m_div = 1'b0;

    function automatic bit high_at(int t);
        int hi, lo, first;
        if (t < 0) return 1'b0;
        hi    = m_per / 2;
        lo    = m_per - hi;
        first = m_ph + lo;
        if (t < first) return 1'b0;
        return ((t - first) % m_per) < hi;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o     = '0;
        o.rdy = 1'b1;
        return o;
    endfunction

    task automatic model_reset();
        m_per = 2;
        m_ph  = 0;
        m_act = 1'b0;
        m_div = 1'b0;
        m_t   = 0;
    endtask

    task automatic model_step(input bit en, input bit cv, input int cp, input int cph);
        obs_t o;
        bit   nd;
        o = '0;
        if (!rst_n) begin
            model_reset();
            exp_q.push_back(reset_obs());
            return;
        end
        if (!m_act) begin
            if (cv) begin
                if (cp >= 2) begin
                    m_per = cp;
                    m_ph  = cph;
                end else begin
                    o.err = 1'b1;
                end
            end else if (en) begin
                m_act = 1'b1;
                m_t   = 0;
            end
        end else begin
            m_t++;
            // A high half is never cut short; anything else stops immediately.
            if (!en && !(high_at(m_t - 1) && high_at(m_t))) m_act = 1'b0;
        end
        nd     = m_act && high_at(m_t);
        o.div  = nd;
        o.rise = nd && !m_div;
        o.fall = m_div && !nd;
        o.run  = m_act;
        o.rdy  = !m_act;
        m_div  = nd;
        exp_q.push_back(o);
    endtask

    task automatic cyc(input bit en, input bit cv = 1'b0, input int cp = 0, input int cph = 0);
        enable     = en;
        cfg_valid  = cv;
        cfg_period = CNT_W'(cp);
        cfg_phase  = CNT_W'(cph);
        @(posedge clk);
        model_step(en, cv, cp, cph);
        #1;
    endtask

    task automatic run_for(input int n);
        repeat (n) cyc(1'b1);
    endtask

    task automatic idle_for(input int n);
        repeat (n) cyc(1'b0);
    endtask

    task automatic async_rst();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (div_clk !== 1'b0 || running !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: div_clk=%b running=%b cfg_ready=%b, required 0 0 1",
                     div_clk, running, cfg_ready);
        end
        exp_q.delete();
        model_reset();
        exp_q.push_back(reset_obs());
    endtask

    initial begin : monitor
        obs_t e, g;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {div_clk, rise_stb, fall_stb, running, cfg_ready, cfg_err};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: div/rise/fall/run/rdy/err got %b required %b",
                             $time, g, e);
                end
            end
        end
    end

    initial begin : driver
        bit en_r;
        // Reset held, then defaults give period 2 with no phase.
        idle_for(3);
        rst_n = 1'b1;
        idle_for(2);
        run_for(10);
        idle_for(4);

        // Period 4, phase 3: first rise five edges after start.
        cyc(1'b0, 1'b1, 4, 3);
        run_for(20);
        idle_for(6);

        // Odd period, then a rejected configuration that must not disturb it.
        cyc(1'b0, 1'b1, 5, 0);
        run_for(16);
        idle_for(6);
        cyc(1'b0, 1'b1, 1, 7);
        cyc(1'b0, 1'b1, 0, 2);
        idle_for(2);
        run_for(12);
        idle_for(6);

        // Stop requested in the first high cycle of period 8.
        cyc(1'b0, 1'b1, 8, 0);
        run_for(5);
        idle_for(8);

        // Stop during PHASE, then during LO.
        cyc(1'b0, 1'b1, 6, 10);
        run_for(3);
        idle_for(4);
        cyc(1'b0, 1'b1, 8, 2);
        run_for(4);
        idle_for(4);

        // Asynchronous reset in the middle of a high half.
        cyc(1'b0, 1'b1, 6, 0);
        run_for(5);
        async_rst();
        idle_for(2);
        rst_n = 1'b1;
        run_for(8);
        idle_for(3);

        // Configuration and enable together: configuration first, run next edge.
        cyc(1'b1, 1'b1, 6, 1);
        run_for(15);
        idle_for(6);

        // Random traffic.
        en_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 6) en_r = !en_r;
            if ($urandom_range(0, 99) < 10)
                cyc(en_r, 1'b1, int'($urandom_range(0, 12)), int'($urandom_range(0, 6)));
            else
                cyc(en_r);
        end
        idle_for(10);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/osc_ctrl.md
# osc_ctrl

Synthesizable, programmable clock generator and controller for the verify platform. It derives a divided clock from the system clock using a configured period and phase offset. Start and stop are sequenced so no runt pulse is ever produced. Configuration is loaded through a valid/ready handshake while idle. It replaces the behavioural oscillator model wherever the derived clock must exist in hardware, for example to pace the AES core stimulus.

## Interface
- `CNT_W`, default 32: width of period, phase and internal counters.
- `RST_PERIOD`, default 2: period loaded at reset. Must be ≥ 2.
- `clk` input, 1: system clock. All logic is on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `enable` input, 1: run request. Level-sensitive.
- `cfg_valid` input, 1: a new configuration is offered.
- `cfg_ready` output, 1: configuration can be accepted. Reset value 1.
- `cfg_period` input, CNT_W: output period in `clk` cycles. Must be ≥ 2.
- `cfg_phase` input, CNT_W: delay in cycles from start to the beginning of the first low half.
- `cfg_err` output, 1: one-cycle pulse when a configuration is rejected. Reset value 0.
- `div_clk` output, 1: generated clock, registered. Reset value 0.
- `rise_stb` output, 1: high in the first cycle of each high half. Reset value 0.
- `fall_stb` output, 1: high in the cycle `div_clk` returns to 0. Reset value 0.
- `running` output, 1: high while state ≠ IDLE. Reset value 0.

## Operation

**Configuration registers**
- `per_q` resets to `RST_PERIOD`; `ph_q` resets to 0.
- Half lengths: `hi_len = per_q >> 1`; `lo_len = per_q - hi_len`. The low half is longer for odd periods.

**Configuration handshake**
- `cfg_ready` = 1 only in IDLE.
- A configuration is accepted on `cfg_valid & cfg_ready`.
- If `cfg_period < 2`, the configuration is rejected: `cfg_err` pulses the next cycle and both registers are unchanged.
- If `cfg_valid` and `enable` are both high in IDLE, the configuration wins. The block stays in IDLE for that cycle and starts with the new configuration on the following edge.

**States**
- IDLE: `div_clk` = 0.
  - `enable` = 1 and `ph_q` ≠ 0: go to PHASE, counter = `ph_q - 1`.
  - `enable` = 1 and `ph_q` = 0: go to LO, counter = `lo_len - 1`.
- PHASE: `div_clk` = 0.
  - `enable` = 0: go to IDLE.
  - Counter = 0: go to LO, counter = `lo_len - 1`.
  - Otherwise decrement the counter.
- LO: `div_clk` = 0.
  - `enable` = 0: go to IDLE.
  - Counter = 0: go to HI, counter = `hi_len - 1`, and `rise_stb` is asserted.
- HI: `div_clk` = 1. `enable` is ignored until the half completes.
  - Counter = 0 and `enable` = 1: go to LO, counter = `lo_len - 1`, and `fall_stb` is asserted.
  - Counter = 0 and `enable` = 0: go to IDLE, and `fall_stb` is asserted.

**Boundary conditions**
- Every high half lasts exactly `hi_len` cycles, including the last one before a stop.
- Every low half lasts `lo_len` cycles, unless it is cut short by a stop (the output is already low, so this is safe).
- `per_q` and `ph_q` cannot change while running, so there are no mid-period reconfigurations.
- Asserting `rst_n` low at any point forces `div_clk` = 0 and the state to IDLE immediately. The configuration returns to its reset values.
- The counter never wraps: it is reloaded at every transition.

## Timing
- Latency from `enable` sampled high at edge E0 (state IDLE) to the first `div_clk` rise: edge E0 + `ph_q` + `lo_len`.
- Steady state: `div_clk` repeats every `per_q` cycles. `rise_stb` and `fall_stb` each fire once per period, aligned with the `div_clk` edge they mark.
- Stop latency from `enable` sampled low:
  - from PHASE or LO: 1 cycle;
  - from HI: the remaining high cycles.
- `running` deasserts on the same edge `div_clk` falls, or on the same edge IDLE is entered.
- `cfg_err` is registered: 1-cycle latency from the rejected handshake.

## Structure
- Package `osc_ctrl_pkg`: state enum `osc_state_e` (IDLE, PHASE, LO, HI) and constant `OSC_MIN_PERIOD = 2`.
- Sub-module `osc_downcnt`: a `CNT_W`-bit loadable down-counter with inputs `load`/`load_val` and output `zero`, instantiated once.
- Everything else is one state register plus registered outputs in `osc_ctrl`.

## Test plan
- **Reset:** hold `rst_n` = 0 → `div_clk`, `rise_stb`, `fall_stb`, `running`, `cfg_err` are all 0 and `cfg_ready` = 1. Release and raise `enable` with defaults → `div_clk` toggles every cycle (period 2, `ph_q` = 0).
- **Period 4, phase 3:** load period 4, phase 3, then assert `enable` at E0 → `div_clk` low until E0+5, high for 2 cycles, then repeats with period 4. `rise_stb` fires at E0+5, E0+9, …
- **Odd period / rejection:** load period 5 → high 2, low 3. Then offer period 1 in IDLE → `cfg_err` pulses once and a later run still shows period 5.
- **Stop during HI:** with period 8, drop `enable` in the first high cycle → `div_clk` stays high 4 cycles total, then falls with `fall_stb`, and `running` drops on the same edge.
- **Stop during PHASE and LO:** with phase 10, drop `enable` at the 3rd phase cycle → IDLE next cycle with no `div_clk` pulse. Repeat inside LO → same result.
- **Async reset and config/enable collision:** assert `rst_n` low mid-HI → `div_clk` = 0 asynchronously and the configuration returns to period 2. Separately, assert `cfg_valid` and `enable` together in IDLE → configuration accepted and the run starts one cycle later using the new period.
